// File: rtl/spi_slave_axis_egress_os.sv
// rtl/spi_slave_axis_egress_os.sv - oversampled SPI-slave egress: AXIS word FIFO serialised onto 1/2/4 MISO lanes
module spi_slave_axis_egress_os #(
  parameter int MISO_SIZE   = 1,
  parameter int MSB_FIRST   = 1,
  parameter int WORD_BYTES  = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    resn,
  input  logic                    spi_clk,
  input  logic                    spi_csn,
  output logic [MISO_SIZE-1:0]    spi_miso,
  output logic                    spi_miso_oe,
  input  logic [8*WORD_BYTES-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [7:0]              s_axis_tuser,
  output logic [15:0]             underrun_count,
  output logic                    frame_abort
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(WORD_BYTES - 1);
  localparam logic [3:0]    STEP      = 4'(MISO_SIZE);
  localparam logic [3:0]    LAST_CNT  = 4'(8 - MISO_SIZE);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sck_sync, csn_sync;
  logic                    sck_d, csn_d;
  logic                    csn_fall, csn_rise, sck_fall;
  logic [8*WORD_BYTES-1:0] mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr, rd_ptr;
  logic                    full, empty, push, pop, ready_en;
  logic [7:0]              shifter, head_byte, next_byte;
  logic [3:0]              bit_cnt;
  logic [BW-1:0]           byte_idx;
  logic [15:0]             underrun_q;
  logic                    load;

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      sck_sync <= '0;
      csn_sync <= '1;
      sck_d    <= 1'b0;
      csn_d    <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
      csn_sync <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      sck_d    <= sck_sync[SYNC_STAGES-1];
      csn_d    <= csn_sync[SYNC_STAGES-1];
    end
  end

  assign csn_fall = csn_d & ~csn_sync[SYNC_STAGES-1];
  assign csn_rise = ~csn_d & csn_sync[SYNC_STAGES-1];
  assign sck_fall = sck_d & ~sck_sync[SYNC_STAGES-1];

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = s_axis_tvalid & s_axis_tready;
  assign s_axis_tready = ready_en & ~full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
  end

  // A byte slot opens on frame start and when a byte's last lane group has been shifted;
  // an sck_fall that coincides with csn_rise never opens one.
  always_comb begin
    load = 1'b0;
    if (state == IDLE) load = csn_fall;
    else               load = ~csn_rise & sck_fall & ((bit_cnt + STEP) == 4'd8);
  end

  assign head_byte = mem[rd_ptr[AW-1:0]][{byte_idx, 3'b000} +: 8];
  assign next_byte = empty ? s_axis_tuser : head_byte;
  assign pop       = load & ~empty & (byte_idx == LAST_BYTE);

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ready_en   <= 1'b0;
      shifter    <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      underrun_q <= '0;
      frame_abort <= 1'b0;
    end else begin
      ready_en    <= 1'b1;
      frame_abort <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (load) begin
        shifter <= next_byte;
        bit_cnt <= '0;
        if (empty) begin
          if (underrun_q != 16'hFFFF) underrun_q <= underrun_q + 16'd1;
        end else begin
          byte_idx <= (byte_idx == LAST_BYTE) ? '0 : byte_idx + 1'b1;
        end
      end
      case (state)
        IDLE: if (csn_fall) state <= SHIFT;
        SHIFT: begin
          if (csn_rise) begin
            state <= IDLE;
            // A byte whose final lane group is already on the pins counts as delivered.
            if (bit_cnt != 4'd0 && bit_cnt != LAST_CNT) frame_abort <= 1'b1;
            bit_cnt <= '0;
          end else if (sck_fall && !load) begin
            bit_cnt <= bit_cnt + STEP;
            shifter <= (MSB_FIRST != 0) ? (shifter << MISO_SIZE) : (shifter >> MISO_SIZE);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign spi_miso       = (state == SHIFT) ?
                          ((MSB_FIRST != 0) ? shifter[7 -: MISO_SIZE] : shifter[MISO_SIZE-1:0]) : '0;
  assign spi_miso_oe    = (state == SHIFT);
  assign underrun_count = underrun_q;

endmodule
